// File: rtl/ascon_enc_ctrl_if.sv
// Control bundle between the ASCON-128 sequencer, its block source
// and the permutation datapath it steers.
interface ascon_enc_ctrl_if;
    logic       start_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       en_reg_state_o;
    logic       mod_o;
    logic [3:0] round_o;
    logic       en_xor_data_o;
    logic       en_xor_begin_key_o;
    logic       en_xor_lsb_o;
    logic       en_xor_end_key_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic       cipher_valid_o;
    logic       busy_o;
    logic       done_o;

    modport slave (
        input  start_i,
        input  data_valid_i,
        output data_ready_o,
        output en_reg_state_o,
        output mod_o,
        output round_o,
        output en_xor_data_o,
        output en_xor_begin_key_o,
        output en_xor_lsb_o,
        output en_xor_end_key_o,
        output en_cipher_o,
        output en_tag_o,
        output cipher_valid_o,
        output busy_o,
        output done_o
    );

    modport master (
        output start_i,
        output data_valid_i,
        input  data_ready_o,
        input  en_reg_state_o,
        input  mod_o,
        input  round_o,
        input  en_xor_data_o,
        input  en_xor_begin_key_o,
        input  en_xor_lsb_o,
        input  en_xor_end_key_o,
        input  en_cipher_o,
        input  en_tag_o,
        input  cipher_valid_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/ascon_enc_ctrl.sv
// ASCON-128 encryption sequencer: init (pa), one AD block (pb),
// NB_BLOCKS-1 plaintext blocks (pb) and finalization (pa).
module ascon_enc_ctrl #(
    parameter int NB_BLOCKS = 4
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    ascon_enc_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_AD,
        S_AD,
        S_WAIT_PT,
        S_PT,
        S_WAIT_FIN,
        S_FINAL,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_RND = 4'd11;
    localparam logic [3:0] PB_RND   = 4'd6;
    localparam logic [3:0] LAST_BLK = 4'(NB_BLOCKS - 1);

    state_e     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic [3:0] blk_q, blk_d;
    logic       cipher_valid_q, cipher_valid_d;

    logic       en_cipher;
    logic       dv;

    assign dv = bus.data_valid_i;

    always_ff @(posedge clock_i or posedge resetb_i) begin
        if (resetb_i) begin
            state_q        <= S_IDLE;
            rnd_q          <= 4'd0;
            blk_q          <= 4'd0;
            cipher_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rnd_q          <= rnd_d;
            blk_q          <= blk_d;
            cipher_valid_q <= cipher_valid_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        rnd_d                  = rnd_q;
        blk_d                  = blk_q;
        en_cipher              = 1'b0;
        bus.data_ready_o       = 1'b0;
        bus.en_reg_state_o     = 1'b0;
        bus.mod_o              = 1'b0;
        bus.en_xor_data_o      = 1'b0;
        bus.en_xor_begin_key_o = 1'b0;
        bus.en_xor_lsb_o       = 1'b0;
        bus.en_xor_end_key_o   = 1'b0;
        bus.en_tag_o           = 1'b0;
        bus.done_o             = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                bus.done_o = (state_q == S_DONE);
                if (bus.start_i) begin
                    state_d = S_INIT;
                    rnd_d   = 4'd0;
                    blk_d   = 4'd0;
                end
            end
            S_INIT: begin
                bus.en_reg_state_o = 1'b1;
                bus.mod_o          = (rnd_q != 4'd0);
                if (rnd_q == LAST_RND) begin
                    bus.en_xor_end_key_o = 1'b1;
                    state_d = S_WAIT_AD;
                    rnd_d   = PB_RND;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            // Wait states hold rnd at the round the accept cycle will run.
            S_WAIT_AD, S_WAIT_PT: begin
                if (dv) begin
                    bus.en_reg_state_o = 1'b1;
                    bus.mod_o          = 1'b1;
                    bus.en_xor_data_o  = 1'b1;
                    bus.data_ready_o   = 1'b1;
                    en_cipher          = (state_q == S_WAIT_PT);
                    state_d = (state_q == S_WAIT_AD) ? S_AD : S_PT;
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            S_AD: begin
                bus.en_reg_state_o = 1'b1;
                bus.mod_o          = 1'b1;
                if (rnd_q == LAST_RND) begin
                    bus.en_xor_lsb_o = 1'b1;
                    if (NB_BLOCKS > 1) begin
                        state_d = S_WAIT_PT;
                        rnd_d   = PB_RND;
                    end else begin
                        state_d = S_WAIT_FIN;
                        rnd_d   = 4'd0;
                    end
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_PT: begin
                bus.en_reg_state_o = 1'b1;
                bus.mod_o          = 1'b1;
                if (rnd_q == LAST_RND) begin
                    blk_d = blk_q + 4'd1;
                    if ((blk_q + 4'd1) < LAST_BLK) begin
                        state_d = S_WAIT_PT;
                        rnd_d   = PB_RND;
                    end else begin
                        state_d = S_WAIT_FIN;
                        rnd_d   = 4'd0;
                    end
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_WAIT_FIN: begin
                if (dv) begin
                    bus.en_reg_state_o     = 1'b1;
                    bus.mod_o              = 1'b1;
                    bus.en_xor_data_o      = 1'b1;
                    bus.en_xor_begin_key_o = 1'b1;
                    bus.data_ready_o       = 1'b1;
                    en_cipher              = 1'b1;
                    state_d = S_FINAL;
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            S_FINAL: begin
                bus.en_reg_state_o = 1'b1;
                bus.mod_o          = 1'b1;
                if (rnd_q == LAST_RND) begin
                    bus.en_xor_end_key_o = 1'b1;
                    bus.en_tag_o         = 1'b1;
                    state_d = S_DONE;
                    rnd_d   = 4'd0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rnd_d   = 4'd0;
                blk_d   = 4'd0;
            end
        endcase

        cipher_valid_d = en_cipher;
    end

    assign bus.round_o        = rnd_q;
    assign bus.en_cipher_o    = en_cipher;
    assign bus.cipher_valid_o = cipher_valid_q;
    assign bus.busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_ascon_enc_ctrl.sv
// Bench for ascon_enc_ctrl: a schedule-list model of the message
// (NB_BLOCKS=4 and NB_BLOCKS=1 instances) checked every cycle.
module tb_ascon_enc_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_enc_ctrl_if ifa ();
    ascon_enc_ctrl_if ifb ();

    ascon_enc_ctrl #(.NB_BLOCKS(4)) dut_a (
        .clock_i (clk),
        .resetb_i(rst),
        .bus     (ifa)
    );

    ascon_enc_ctrl #(.NB_BLOCKS(1)) dut_b (
        .clock_i (clk),
        .resetb_i(rst),
        .bus     (ifb)
    );

    logic start_v [2];
    logic dv_v    [2];

    assign ifa.start_i      = start_v[0];
    assign ifa.data_valid_i = dv_v[0];
    assign ifb.start_i      = start_v[1];
    assign ifb.data_valid_i = dv_v[1];

    // {round,mod,xd,xbk,xlsb,xek,cipher,tag,reg,ready,busy,done,cvalid}
    logic [15:0] dut_vec [2];
    assign dut_vec[0] = {ifa.round_o, ifa.mod_o, ifa.en_xor_data_o,
        ifa.en_xor_begin_key_o, ifa.en_xor_lsb_o, ifa.en_xor_end_key_o,
        ifa.en_cipher_o, ifa.en_tag_o, ifa.en_reg_state_o,
        ifa.data_ready_o, ifa.busy_o, ifa.done_o, ifa.cipher_valid_o};
    assign dut_vec[1] = {ifb.round_o, ifb.mod_o, ifb.en_xor_data_o,
        ifb.en_xor_begin_key_o, ifb.en_xor_lsb_o, ifb.en_xor_end_key_o,
        ifb.en_cipher_o, ifb.en_tag_o, ifb.en_reg_state_o,
        ifb.data_ready_o, ifb.busy_o, ifb.done_o, ifb.cipher_valid_o};

    typedef struct packed {
        logic [3:0] rnd;
        logic mod, xd, xbk, xlsb, xek, ciph, tag, acc;
    } ent_t;

    ent_t sched [2][128];
    int   head  [2];
    int   len   [2];
    bit   mbusy [2] = '{1'b0, 1'b0};
    bit   mdone [2] = '{1'b0, 1'b0};
    bit   mcv   [2] = '{1'b0, 1'b0};

    int checks   = 0;
    int failures = 0;

    function automatic ent_t mk(input int r, input bit m, input bit xd,
                                input bit xbk, input bit xlsb, input bit xek,
                                input bit c, input bit t, input bit a);
        ent_t e;
        e.rnd = 4'(r);
        e.mod = m; e.xd = xd; e.xbk = xbk; e.xlsb = xlsb;
        e.xek = xek; e.ciph = c; e.tag = t; e.acc = a;
        return e;
    endfunction

    // One entry per round the message must execute, in order.
    task automatic build(input int i, input int nb);
        int n;
        n = 0;
        for (int r = 0; r < 12; r++) begin
            sched[i][n] = mk(r, r != 0, 0, 0, 0, r == 11, 0, 0, 0); n++;
        end
        sched[i][n] = mk(6, 1, 1, 0, 0, 0, 0, 0, 1); n++;
        for (int r = 7; r < 12; r++) begin
            sched[i][n] = mk(r, 1, 0, 0, r == 11, 0, 0, 0, 0); n++;
        end
        for (int b = 1; b < nb; b++) begin
            sched[i][n] = mk(6, 1, 1, 0, 0, 0, 1, 0, 1); n++;
            for (int r = 7; r < 12; r++) begin
                sched[i][n] = mk(r, 1, 0, 0, 0, 0, 0, 0, 0); n++;
            end
        end
        sched[i][n] = mk(0, 1, 1, 1, 0, 0, 1, 0, 1); n++;
        for (int r = 1; r < 12; r++) begin
            sched[i][n] = mk(r, 1, 0, 0, 0, r == 11, 0, r == 11, 0); n++;
        end
        head[i] = 0;
        len[i]  = n;
    endtask

    function automatic logic [15:0] expv(input int i);
        logic [15:0] v;
        ent_t e;
        v = 16'h0;
        if (rst) return v;
        if (!mbusy[i]) begin
            v[1] = mdone[i];
            v[0] = mcv[i];
            return v;
        end
        e = sched[i][head[i]];
        if (e.acc && !dv_v[i]) begin
            v[15:12] = e.rnd;
            v[2]     = 1'b1;
            v[0]     = mcv[i];
        end else begin
            v = {e.rnd, e.mod, e.xd, e.xbk, e.xlsb, e.xek, e.ciph, e.tag,
                 1'b1, e.acc, 1'b1, 1'b0, mcv[i]};
        end
        return v;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [15:0] v;
            if (rst) begin
                mbusy[i] = 1'b0;
                mdone[i] = 1'b0;
                mcv[i]   = 1'b0;
            end else begin
                v      = expv(i);
                mcv[i] = v[6];
                if (mbusy[i]) begin
                    if (v[4]) begin
                        head[i] = head[i] + 1;
                        if (head[i] == len[i]) begin
                            mbusy[i] = 1'b0;
                            mdone[i] = 1'b1;
                        end
                    end
                end else if (start_v[i]) begin
                    build(i, (i == 0) ? 4 : 1);
                    mbusy[i] = 1'b1;
                    mdone[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [15:0] e;
            e = expv(i);
            checks++;
            if (dut_vec[i] !== e) begin
                failures++;
                $display("FAIL cycle_vec[%0d] t=%0t: got %h expected %h",
                         i, $time, dut_vec[i], e);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int ac [2];
    int ncip [2];
    int cpa [4];
    int tag_at [2];
    int done_at;
    int n;
    int st;

    initial begin
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        dv_v[0]    = 1'b1; dv_v[1]    = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle with data offered: nothing may be consumed.
        repeat (20) @(negedge clk);
        chk("idle_ready", int'(ifa.data_ready_o), 0);
        chk("idle_vec", int'(dut_vec[0]), 0);

        // Full message on both instances, data always valid.
        @(posedge clk); #1;
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        ac[0] = 0; ac[1] = 0; ncip[0] = 0; ncip[1] = 0;
        tag_at[0] = 0; tag_at[1] = 0; done_at = 0;
        cpa[0] = 0; cpa[1] = 0; cpa[2] = 0; cpa[3] = 0;
        n = 0;
        while (n < 200 && done_at == 0) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 2; i++) begin
                if (dut_vec[i][4]) ac[i]++;
                if (dut_vec[i][6]) begin
                    if (i == 0 && ncip[0] < 4) cpa[ncip[0]] = ac[0];
                    ncip[i]++;
                end
                if (dut_vec[i][5]) tag_at[i] = ac[i];
            end
            if (dut_vec[0][1]) done_at = n;
        end
        chk("run_a_active", ac[0], 48);
        chk("run_a_cipher_n", ncip[0], 4);
        chk("run_a_cipher0", cpa[0], 19);
        chk("run_a_cipher1", cpa[1], 25);
        chk("run_a_cipher2", cpa[2], 31);
        chk("run_a_cipher3", cpa[3], 37);
        chk("run_a_tag", tag_at[0], 48);
        chk("run_a_done_at", done_at, 49);
        chk("run_b_active", ac[1], 30);
        chk("run_b_cipher_n", ncip[1], 1);
        chk("run_b_tag", tag_at[1], 30);

        // Stall five cycles in front of the first plaintext block.
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1 dv_v[0] = 1'b0;
        @(posedge clk);
        st = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifa.busy_o && !ifa.en_reg_state_o && ifa.round_o == 4'd6)
                st++;
        end
        chk("stall_cycles", st, 5);
        @(posedge clk); #1 dv_v[0] = 1'b1;
        @(negedge clk);
        chk("resume_round", int'(ifa.round_o), 6);
        chk("resume_xd", int'(ifa.en_xor_data_o), 1);
        chk("resume_reg", int'(ifa.en_reg_state_o), 1);

        // start_i pulse during finalization must be ignored.
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        n = 0;
        while (n < 100 && !ifa.done_o) begin
            @(negedge clk);
            n++;
        end
        chk("stall_run_done", int'(ifa.done_o), 1);

        // Restart from DONE.
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        @(negedge clk);
        chk("restart_round", int'(ifa.round_o), 0);
        chk("restart_mod", int'(ifa.mod_o), 0);
        chk("restart_busy", int'(ifa.busy_o), 1);

        // Reset asserted at PT round 8.
        repeat (20) @(posedge clk);
        #1;
        chk("pre_reset_round", int'(ifa.round_o), 8);
        rst = 1'b1;
        #1;
        chk("reset_vec", int'(dut_vec[0]), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", int'(ifa.busy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
